// File: rtl/i3c_csr_arbiter.sv
// i3c_csr_arbiter: round-robin arbiter and sequencer sharing the single I3C
// CSR register port between NumReq requesters. Only one CSR access is
// outstanding at a time. Each requester gets a valid/ready request handshake
// and a one-cycle response pulse.
// Optional feature: define I3C_CSR_ARB_TIMEOUT_EN to force an error response
// after TimeoutCycles cycles in WAIT without a matching ack.
module i3c_csr_arbiter #(
  parameter int NumReq        = 2,
  parameter int CsrAddrWidth  = 12,
  parameter int CsrDataWidth  = 32,
  parameter int TimeoutCycles = 255
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [NumReq-1:0]              req_valid_i,
  output logic [NumReq-1:0]              req_ready_o,
  input  logic [NumReq-1:0]              req_write_i,
  input  logic [NumReq*CsrAddrWidth-1:0] req_addr_i,
  input  logic [NumReq*CsrDataWidth-1:0] req_wdata_i,
  output logic [NumReq-1:0]              resp_valid_o,
  output logic [CsrDataWidth-1:0]        resp_rdata_o,
  output logic                           resp_err_o,
  output logic                           csr_req_o,
  output logic                           csr_req_is_wr_o,
  output logic [CsrAddrWidth-1:0]        csr_addr_o,
  output logic [CsrDataWidth-1:0]        csr_wr_data_o,
  input  logic                           csr_req_stall_i,
  input  logic                           csr_rd_ack_i,
  input  logic [CsrDataWidth-1:0]        csr_rd_data_i,
  input  logic                           csr_rd_err_i,
  input  logic                           csr_wr_ack_i,
  input  logic                           csr_wr_err_i,
  output logic                           timeout_o
);

  localparam int IdxW = (NumReq > 1) ? $clog2(NumReq) : 1;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_e;

  state_e                  state, state_d;
  logic [IdxW-1:0]         rr_ptr, rr_ptr_d;
  logic [IdxW-1:0]         gnt, gnt_d;
  logic                    wr_q, wr_d;
  logic [CsrAddrWidth-1:0] addr_q, addr_d;
  logic [CsrDataWidth-1:0] wdata_q, wdata_d;
  logic [CsrDataWidth-1:0] rdata_q, rdata_d;
  logic                    err_q, err_d;

`ifdef I3C_CSR_ARB_TIMEOUT_EN
  localparam int CntW = $clog2(TimeoutCycles + 1);
  logic [CntW-1:0]         cnt_q, cnt_d;
  logic                    to_q, to_d;
`endif

  logic [CsrAddrWidth-1:0] addr_arr  [NumReq];
  logic [CsrDataWidth-1:0] wdata_arr [NumReq];
  logic                    ack;
  logic                    ack_err;
  logic [CsrDataWidth-1:0] ack_data;

  // Unpack the per-requester address/data slices
  always_comb begin
    for (int unsigned i = 0; i < NumReq; i++) begin
      addr_arr[i]  = req_addr_i[i*CsrAddrWidth +: CsrAddrWidth];
      wdata_arr[i] = req_wdata_i[i*CsrDataWidth +: CsrDataWidth];
    end
  end

  // Select the ack matching the direction of the outstanding access
  always_comb begin
    ack      = wr_q ? csr_wr_ack_i : csr_rd_ack_i;
    ack_err  = wr_q ? csr_wr_err_i : csr_rd_err_i;
    ack_data = wr_q ? '0 : csr_rd_data_i;
  end

  // Next-state, capture and output logic
  always_comb begin
    logic            found;
    logic [IdxW-1:0] cand;
    found           = 1'b0;
    cand            = '0;
    state_d         = state;
    rr_ptr_d        = rr_ptr;
    gnt_d           = gnt;
    wr_d            = wr_q;
    addr_d          = addr_q;
    wdata_d         = wdata_q;
    rdata_d         = rdata_q;
    err_d           = err_q;
`ifdef I3C_CSR_ARB_TIMEOUT_EN
    cnt_d           = '0;
    to_d            = to_q;
`endif
    req_ready_o     = '0;
    resp_valid_o    = '0;
    resp_rdata_o    = '0;
    resp_err_o      = 1'b0;
    timeout_o       = 1'b0;
    csr_req_o       = 1'b0;
    csr_req_is_wr_o = wr_q;
    csr_addr_o      = addr_q;
    csr_wr_data_o   = wdata_q;

    case (state)
      IDLE: begin
        // Search starts just after the last served requester
        for (int unsigned i = 1; i <= NumReq; i++) begin
          cand = IdxW'((32'(rr_ptr) + i) % NumReq);
          if (!found && req_valid_i[cand]) begin
            found   = 1'b1;
            gnt_d   = cand;
            wr_d    = req_write_i[cand];
            addr_d  = addr_arr[cand];
            wdata_d = wdata_arr[cand];
          end
        end
        if (found) begin
          req_ready_o[gnt_d] = 1'b1;
          rdata_d            = '0;
          err_d              = 1'b0;
`ifdef I3C_CSR_ARB_TIMEOUT_EN
          to_d               = 1'b0;
`endif
          state_d            = ISSUE;
        end
      end
      ISSUE: begin
        csr_req_o = 1'b1;
        if (!csr_req_stall_i) begin
          if (ack) begin
            rdata_d = ack_data;
            err_d   = ack_err;
            state_d = RESP;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (ack) begin
          rdata_d = ack_data;
          err_d   = ack_err;
          state_d = RESP;
        end
`ifdef I3C_CSR_ARB_TIMEOUT_EN
        else if (cnt_q == CntW'(TimeoutCycles - 1)) begin
          rdata_d = '0;
          err_d   = 1'b1;
          to_d    = 1'b1;
          state_d = RESP;
        end
        cnt_d = cnt_q + 1'b1;
`endif
      end
      RESP: begin
        resp_valid_o[gnt] = 1'b1;
        resp_rdata_o      = rdata_q;
        resp_err_o        = err_q;
`ifdef I3C_CSR_ARB_TIMEOUT_EN
        timeout_o         = to_q;
`endif
        rr_ptr_d          = gnt;
        state_d           = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Outputs are quiet during the reset cycle so an abandoned access never
    // issues, grants or responds.
    if (rst_i) begin
      req_ready_o     = '0;
      resp_valid_o    = '0;
      resp_rdata_o    = '0;
      resp_err_o      = 1'b0;
      timeout_o       = 1'b0;
      csr_req_o       = 1'b0;
      csr_req_is_wr_o = 1'b0;
      csr_addr_o      = '0;
      csr_wr_data_o   = '0;
    end
  end

  // State and capture registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= IDLE;
      rr_ptr  <= IdxW'(NumReq - 1);
      gnt     <= '0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
`ifdef I3C_CSR_ARB_TIMEOUT_EN
      cnt_q   <= '0;
      to_q    <= 1'b0;
`endif
    end else begin
      state   <= state_d;
      rr_ptr  <= rr_ptr_d;
      gnt     <= gnt_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
`ifdef I3C_CSR_ARB_TIMEOUT_EN
      cnt_q   <= cnt_d;
      to_q    <= to_d;
`endif
    end
  end

endmodule

// File: tb/tb_i3c_csr_arbiter.sv
// Scoreboard bench for i3c_csr_arbiter: stimulus pushes expected grants and
// responses into queues, a negedge monitor pops and compares them.
module tb_i3c_csr_arbiter;
  localparam int N  = 2;
  localparam int AW = 12;
  localparam int DW = 32;
  localparam int TO = 8;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_write = '0;
  logic [N*AW-1:0] req_addr  = '0;
  logic [N*DW-1:0] req_wdata = '0;
  logic [N-1:0]    req_ready_o;
  logic [N-1:0]    resp_valid_o;
  logic [DW-1:0]   resp_rdata_o;
  logic            resp_err_o;
  logic            csr_req_o;
  logic            csr_req_is_wr_o;
  logic [AW-1:0]   csr_addr_o;
  logic [DW-1:0]   csr_wr_data_o;
  logic            stall  = 1'b0;
  logic            rd_ack = 1'b0;
  logic [DW-1:0]   rd_data = '0;
  logic            rd_err = 1'b0;
  logic            wr_ack = 1'b0;
  logic            wr_err = 1'b0;
  logic            timeout_o;

  i3c_csr_arbiter #(
    .NumReq(N),
    .CsrAddrWidth(AW),
    .CsrDataWidth(DW),
    .TimeoutCycles(TO)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .req_valid_i(req_valid),
    .req_ready_o(req_ready_o),
    .req_write_i(req_write),
    .req_addr_i(req_addr),
    .req_wdata_i(req_wdata),
    .resp_valid_o(resp_valid_o),
    .resp_rdata_o(resp_rdata_o),
    .resp_err_o(resp_err_o),
    .csr_req_o(csr_req_o),
    .csr_req_is_wr_o(csr_req_is_wr_o),
    .csr_addr_o(csr_addr_o),
    .csr_wr_data_o(csr_wr_data_o),
    .csr_req_stall_i(stall),
    .csr_rd_ack_i(rd_ack),
    .csr_rd_data_i(rd_data),
    .csr_rd_err_i(rd_err),
    .csr_wr_ack_i(wr_ack),
    .csr_wr_err_i(wr_err),
    .timeout_o(timeout_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  typedef struct {
    int          idx;
    logic [31:0] data;
    logic        err;
    logic        to;
  } resp_t;

  int    exp_grant[$];
  resp_t exp_resp[$];
  int    last_resp_cyc = -1;

  task automatic expect_resp(input int idx, input logic [31:0] d, input logic e, input logic t);
    resp_t r;
    r.idx = idx; r.data = d; r.err = e; r.to = t;
    exp_resp.push_back(r);
  endtask

  // Monitor: compares every grant and response against the queues
  always @(negedge clk) begin
    int    g;
    resp_t r;
    if (req_ready_o != '0) begin
      chk("ready_onehot", 64'($countones(req_ready_o)), 64'd1);
      if (exp_grant.size() == 0) chk("unexpected_grant", 64'(req_ready_o), 64'd0);
      else begin
        g = exp_grant.pop_front();
        chk("grant", 64'(req_ready_o), 64'd1 << g);
      end
    end
    if (resp_valid_o != '0) begin
      last_resp_cyc = cyc;
      if (exp_resp.size() == 0) chk("unexpected_resp", 64'(resp_valid_o), 64'd0);
      else begin
        r = exp_resp.pop_front();
        chk("resp_valid", 64'(resp_valid_o), 64'd1 << r.idx);
        chk("resp_rdata", 64'(resp_rdata_o), 64'(r.data));
        chk("resp_err", 64'(resp_err_o), 64'(r.err));
        chk("resp_timeout", 64'(timeout_o), 64'(r.to));
      end
    end else begin
      chk("idle_resp_fields", {31'd0, timeout_o, resp_err_o, resp_rdata_o}, 64'd0);
    end
  end

  // CSR responder model, reconfigured per test
  int          stall_left = 0;
  int          ack_delay = 0;
  int          pending = 0;
  bit          inject_wrong = 1'b0;
  logic        rsp_err = 1'b0;
  logic [31:0] rsp_base = '0;
  logic        acc_wr = 1'b0;
  logic [11:0] acc_addr = '0;

  task automatic do_ack();
    if (acc_wr) begin
      wr_ack = 1'b1; wr_err = rsp_err;
    end else begin
      rd_ack = 1'b1; rd_err = rsp_err; rd_data = rsp_base ^ {20'd0, acc_addr};
    end
  endtask

  always begin
    @(posedge clk); #1;
    rd_ack = 1'b0; wr_ack = 1'b0; rd_err = 1'b0; wr_err = 1'b0; rd_data = '0; stall = 1'b0;
    if (csr_req_o) begin
      if (stall_left > 0) begin
        stall = 1'b1;
        stall_left--;
      end else begin
        acc_wr = csr_req_is_wr_o;
        acc_addr = csr_addr_o;
        if (ack_delay == 0) do_ack();
        else if (ack_delay > 0) pending = ack_delay;
      end
    end else if (pending > 0) begin
      pending--;
      if (inject_wrong) begin
        inject_wrong = 1'b0;
        if (acc_wr) rd_ack = 1'b1; else wr_ack = 1'b1;
      end
      if (pending == 0) do_ack();
    end
  end

  // Raise a request and hold it until the grant is seen
  task automatic request(input int k, input bit wr, input logic [11:0] a,
                         input logic [31:0] d, output int gcyc);
    bit got = 1'b0;
    gcyc = -1;
    req_write[k] = wr;
    req_addr[k*AW +: AW] = a;
    req_wdata[k*DW +: DW] = d;
    req_valid[k] = 1'b1;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (req_ready_o[k]) begin got = 1'b1; gcyc = cyc; break; end
    end
    chk("grant_seen", 64'(got), 64'd1);
    @(posedge clk); #1;
    req_valid[k] = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    for (int n = 0; n < budget; n++) begin
      if (exp_grant.size() == 0 && exp_resp.size() == 0) break;
      @(negedge clk); #1;
    end
    chk("drain", 64'(exp_grant.size() + exp_resp.size()), 64'd0);
  endtask

  initial begin
    int g, g0, g1, rc, busy;
    int rem [2];

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_ctrl", {56'd0, req_ready_o, resp_valid_o, resp_err_o, timeout_o, csr_req_o, csr_req_is_wr_o}, 64'd0);
    chk("reset_csr_fields", {20'd0, csr_addr_o, csr_wr_data_o}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Single read, zero stall, same-cycle ack
    rsp_base = 32'hDEADBEEF ^ 32'h010; ack_delay = 0; rsp_err = 1'b0;
    exp_grant.push_back(0);
    expect_resp(0, 32'hDEADBEEF, 1'b0, 1'b0);
    request(0, 1'b0, 12'h010, 32'h0, g);
    @(negedge clk);
    chk("t1_csr_req", {50'd0, csr_req_o, csr_req_is_wr_o, csr_addr_o}, {50'd0, 1'b1, 1'b0, 12'h010});
    wait_done(20);
    chk("t1_latency", 64'(last_resp_cyc - g), 64'd2);

    // Write with 3 stall cycles, wr_ack 2 cycles after acceptance
    stall_left = 3; ack_delay = 2;
    exp_grant.push_back(1);
    expect_resp(1, 32'h0, 1'b0, 1'b0);
    request(1, 1'b1, 12'h3A4, 32'h12345678, g);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t3_hold", {19'd0, csr_req_o, csr_req_is_wr_o, csr_addr_o, csr_wr_data_o},
          {19'd0, 1'b1, 1'b1, 12'h3A4, 32'h12345678});
    end
    @(negedge clk);
    chk("t3_released", 64'(csr_req_o), 64'd0);
    wait_done(20);
    chk("t3_latency", 64'(last_resp_cyc - g), 64'd7);

    // Both requesters continuously valid: grants 0,1,0,1
    rsp_base = 32'h0BAD0000; ack_delay = 0;
    exp_grant.push_back(0); exp_grant.push_back(1);
    exp_grant.push_back(0); exp_grant.push_back(1);
    expect_resp(0, 32'h0BAD0100, 1'b0, 1'b0);
    expect_resp(1, 32'h0BAD0200, 1'b0, 1'b0);
    expect_resp(0, 32'h0BAD0101, 1'b0, 1'b0);
    expect_resp(1, 32'h0BAD0201, 1'b0, 1'b0);
    req_write = '0;
    req_addr = {12'h200, 12'h100};
    req_valid = 2'b11;
    rem[0] = 2; rem[1] = 2;
    for (int n = 0; n < 60 && (rem[0] + rem[1]) > 0; n++) begin
      int k;
      @(negedge clk);
      k = req_ready_o[0] ? 0 : (req_ready_o[1] ? 1 : -1);
      if (k >= 0) begin
        @(posedge clk); #1;
        rem[k]--;
        if (rem[k] == 0) req_valid[k] = 1'b0;
        else req_addr[k*AW +: AW] = req_addr[k*AW +: AW] + 12'd1;
      end
    end
    chk("t2_all_granted", 64'(rem[0] + rem[1]), 64'd0);
    wait_done(20);

    // Read error with a stray wr_ack during WAIT
    rsp_base = 32'h5A5A5A5A; rsp_err = 1'b1; ack_delay = 3; inject_wrong = 1'b1;
    exp_grant.push_back(0);
    expect_resp(0, 32'h5A5A5A0F, 1'b1, 1'b0);
    request(0, 1'b0, 12'h055, 32'h0, g);
    wait_done(20);
    chk("t4_latency", 64'(last_resp_cyc - g), 64'd5);
    rsp_err = 1'b0;

    // Reset while in WAIT abandons the access; requester 0 wins afterwards
    ack_delay = -1;
    exp_grant.push_back(1);
    request(1, 1'b0, 12'h0AA, 32'h0, g);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    rc = cyc;
    chk("t5_reset_cycle", {60'd0, csr_req_o, req_ready_o[0], resp_valid_o[0], resp_valid_o[1]}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0; ack_delay = 0; rsp_base = 32'h0;
    exp_grant.push_back(0); exp_grant.push_back(1);
    expect_resp(0, 32'h000000C1, 1'b0, 1'b0);
    expect_resp(1, 32'h000000C2, 1'b0, 1'b0);
    req_addr[AW +: AW] = 12'h0C2;
    req_write[1] = 1'b0;
    req_valid[1] = 1'b1;
    request(0, 1'b0, 12'h0C1, 32'h0, g0);
    chk("t5_first_after_reset", 64'(g0 - rc), 64'd1);
    request(1, 1'b0, 12'h0C2, 32'h0, g1);
    wait_done(20);

    // Read that is never acked
    ack_delay = -1;
`ifdef I3C_CSR_ARB_TIMEOUT_EN
    exp_grant.push_back(0);
    expect_resp(0, 32'h0, 1'b1, 1'b1);
    request(0, 1'b0, 12'h0F0, 32'h0, g);
    wait_done(30);
    chk("t6_timeout_latency", 64'(last_resp_cyc - g), 64'd10);
`else
    exp_grant.push_back(0);
    request(0, 1'b0, 12'h0F0, 32'h0, g);
    req_addr[AW +: AW] = 12'h0F1;
    req_valid[1] = 1'b1;
    @(negedge clk);
    busy = 0;
    repeat (100) begin
      @(negedge clk);
      if (req_ready_o != '0 || resp_valid_o != '0 || csr_req_o) busy++;
    end
    chk("t6_stays_in_wait", 64'(busy), 64'd0);
`endif

    chk("queues_drained", 64'(exp_grant.size() + exp_resp.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no completion expected finish before time limit");
    $fatal(1);
  end

endmodule

// File: doc/i3c_csr_arbiter.md
Name: i3c_csr_arbiter

Overview:
- Round-robin arbiter and sequencer that shares the single I3C CSR register port between NumReq requesters, e.g. the host bus frontend (AHB/AXI) and the internal recovery/controller engines.
- Each requester gets a valid/ready request handshake and a one-cycle response pulse.
- Only one CSR access is outstanding at any time.
- Sits between the bus frontends and the CSR block inside i3c_wrapper.

Parameters:
- NumReq, 2, number of requesters (2..8)
- CsrAddrWidth, 12, CSR address width
- CsrDataWidth, 32, CSR data width
- TimeoutCycles, 255, cycles in WAIT before forced error response (only with the optional feature)

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- req_valid_i  in  NumReq  per-requester access request
- req_ready_o  out  NumReq  one-hot grant/accept pulse
- req_write_i  in  NumReq  1 = write, 0 = read
- req_addr_i  in  NumReq*CsrAddrWidth  packed addresses; requester k occupies slice k
- req_wdata_i  in  NumReq*CsrDataWidth  packed write data
- resp_valid_o  out  NumReq  one-hot response pulse
- resp_rdata_o  out  CsrDataWidth  read data, shared by all requesters
- resp_err_o  out  1  error qualifier for resp_valid_o
- csr_req_o  out  1  CSR request
- csr_req_is_wr_o  out  1  CSR request is a write
- csr_addr_o  out  CsrAddrWidth  CSR address
- csr_wr_data_o  out  CsrDataWidth  CSR write data
- csr_req_stall_i  in  1  CSR cannot accept the request this cycle
- csr_rd_ack_i  in  1  read complete
- csr_rd_data_i  in  CsrDataWidth  read data
- csr_rd_err_i  in  1  read error
- csr_wr_ack_i  in  1  write complete
- csr_wr_err_i  in  1  write error
- timeout_o  out  1  one-cycle pulse when an access times out

Behaviour:
- Clocking and reset: one clock. rst_i is sampled at clk_i. On reset:
  - state = IDLE, rr_ptr = NumReq-1 (requester 0 wins first)
  - all outputs 0, captured registers 0
- Reset mid-access: abandons the access. No response is issued. csr_req_o is 0 from the reset cycle onward.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any req_valid_i is set, grant g = first set bit searching rr_ptr+1, rr_ptr+2, … modulo NumReq.
  - req_ready_o[g] = 1 combinationally in the same cycle.
  - Capture write/addr/wdata of g and store g; next state = ISSUE.
  - If no request, stay in IDLE.
- ISSUE:
  - csr_req_o = 1 with the captured fields, held stable while csr_req_stall_i = 1.
  - When stall = 0 the request is taken.
  - If the matching ack (rd_ack for read, wr_ack for write) is also high in that cycle, capture and go to RESP; otherwise go to WAIT.
- WAIT:
  - csr_req_o = 0. Wait for the matching ack, then capture data/err and go to RESP.
  - A non-matching ack is ignored.
- RESP:
  - resp_valid_o[g] = 1 for exactly one cycle.
  - resp_rdata_o = captured read data; 0 for writes.
  - resp_err_o = captured err.
  - rr_ptr = g; next state = IDLE.
  - Responses have no backpressure.
- Outside RESP, resp_valid_o = 0, resp_rdata_o = 0 and resp_err_o = 0.
- Acks arriving in IDLE or RESP are ignored.
- Requesters hold valid and payload until ready. A request withdrawn before ready is simply not granted.
- Latency with zero-stall, same-cycle ack: accept at cycle 0, csr_req_o at cycle 1, resp_valid_o at cycle 2. Minimum 3 cycles per access.
- Fairness: with all requesters continuously requesting, grants rotate 0, 1, …, NumReq-1, 0.
- resp_rdata_o is shared. Only the requester whose resp_valid_o bit is set consumes it.

Optional Feature:
- Macro: I3C_CSR_ARB_TIMEOUT_EN.
- Enabled:
  - A counter clears on entry to WAIT and increments each cycle in WAIT.
  - When it reaches TimeoutCycles with no matching ack, go to RESP with resp_err_o = 1 and rdata = 0, and pulse timeout_o in that RESP cycle.
  - A late ack is ignored unless the arbiter is in ISSUE/WAIT of a later access.
  - The CSR block must not ack more than TimeoutCycles late.
- Disabled: no counter; WAIT waits indefinitely; timeout_o tied 0.

Test Plan:
- Reset then single read: req0 read addr 0x010, zero stall, rd_ack same cycle with data 0xDEADBEEF → ready0 at cycle 0, csr_req_o at cycle 1, resp_valid_o = 01 at cycle 2 with rdata 0xDEADBEEF, err 0.
- Both requesters valid continuously for 4 accesses → grant order 0, 1, 0, 1; never two ready bits high in the same cycle.
- Write with csr_req_stall_i high for 3 cycles → csr_req_o, csr_addr_o and csr_wr_data_o stable for 4 cycles; wr_ack 2 cycles later → resp_valid_o pulse, rdata 0.
- Read with csr_rd_err_i = 1 on ack → resp_err_o = 1 together with resp_valid_o; a wr_ack injected during that read's WAIT is ignored.
- rst_i asserted while in WAIT → next cycle IDLE, no resp_valid_o; after reset, requester 0 granted first.
- With I3C_CSR_ARB_TIMEOUT_EN and TimeoutCycles = 8, read never acked → resp_err_o = 1 and timeout_o pulse 8 cycles after WAIT entry; without the macro → arbiter stays in WAIT for 100 cycles.
